fpa_align: RTL and testbench
============================

# fpa_align

Two-stage pipelined operand aligner for the half-precision floating-point adder. It accepts two IEEE-754 binary16 operands and compares their magnitudes, swapping them so the larger comes first. It then right-shifts the smaller significand with sticky collection and, for effective subtraction, two's-complements it. The resulting pair of 16-bit aligned significands feeds the 16-bit carry-lookahead adder directly, along with the exponent and sign the downstream normaliser needs.

## Interface
- No parameters; field widths are fixed constants in the shared package.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operand pair valid.
- `in_ready` output 1: aligner can accept the operand pair this cycle.
- `in_a` input 16: binary16 operand A.
- `in_b` input 16: binary16 operand B.
- `out_valid` output 1: aligned result valid.
- `out_ready` input 1: downstream accepts the result.
- `out_a` output 16: larger-magnitude significand, aligned.
- `out_b` output 16: smaller significand, shifted, sticky-folded, complemented if subtracting.
- `out_exp` output 5: effective exponent of the larger operand.
- `out_sign` output 1: sign of the larger operand, which is the result sign.
- `out_eff_sub` output 1: signs differ.
- `out_special` output 1: either operand has exp = 31 (Inf/NaN). Data fields are don't-care when this is set.

## Operation
- **Unpack each operand.**
  - Effective exponent: e = exp, or 1 when exp = 0.
  - Hidden bit: h = (exp != 0).
  - Significand: sig = {h, frac[9:0], 5'b0}, i.e. 16 bits with 5 guard bits.
- **Compare/swap (stage 1).** The big operand is the one with the larger {exp, frac}. On a tie, A is big.
  - Registered: d = e_big − e_small (5 bits, unsigned), sig_big, sig_small, sign_big, eff_sub, special.
- **Shift (stage 2).**
  - For d < 16: sh = sig_small >> d.
  - For d ≥ 16: sh = 0.
  - Sticky: OR of all bits shifted out (for d ≥ 16, the OR of all of sig_small). Sticky is ORed into bit 0 of sh.
- **Outputs.**
  - out_a = sig_big.
  - out_b = eff_sub ? (~sh + 1) mod 2^16 : sh.
  - Because sig_big ≥ sh whenever exponents are equal, out_a + out_b (mod 2^16) is the non-negative difference. Carry-out is meaningful only when eff_sub = 0.
- **Handshake.** Valid/ready on both sides; a transfer occurs on a cycle with valid & ready high.
  - in_valid/in_a/in_b are held stable by the upstream until accepted.
- **Stage control.** Each stage holds a valid bit and advances when it is empty or the next stage is advancing.
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv. This is combinational from out_ready; there is no skid buffer.
- **Full-throughput operation.** One result per cycle is produced while out_ready stays high.
- **Backpressure.** While out_ready is low, out_* and out_valid hold stable. Both stages fill, then in_ready falls.
  - No result is dropped or duplicated, and order is preserved.
- **Reset.**
  - All registers clear asynchronously, so out_valid = 0 and all out_* data = 0.
  - in_ready = 1 from the first cycle after release.
  - Assertion mid-operation discards all in-flight pairs.

## Timing
- Latency: a pair accepted at edge N appears with out_valid = 1 after edge N+2, provided both stages were free.
- Stage 1: compare/swap, subtract, special detect.
- Stage 2: barrel shift, sticky, conditional negate. The outputs are registers.
- Simultaneous accept at input and output in the same cycle is legal and sustains throughput.

## Structure
- Package `fpa_pkg` holds:
  - Constants EXP_W = 5, FRAC_W = 10, SIG_W = 16, GUARD_W = 5, EXP_SPECIAL = 5'd31.
  - Struct `fpa_s1_t` for the stage-1 payload: d, sig_big, sig_small, sign, eff_sub, special.
- Sub-module `fpa_align_shift`: combinational 16-bit right shifter with a 5-bit shift amount and sticky fold. It is instantiated once in stage 2.
- The top level contains the unpack logic, compare/swap, both pipeline registers and the handshake control.

## Test plan
- **Same-value add.** Inputs A = 0x3C00, B = 0x3C00 with out_ready = 1.
  - Required 2 cycles later: out_a = 0x8000, out_b = 0x8000, out_exp = 15, out_sign = 0, out_eff_sub = 0.
- **Exponent difference of 1.** Inputs A = 0x3C00, B = 0x3800.
  - Required: d = 1, out_a = 0x8000, out_b = 0x4000, out_exp = 15.
- **Swap with effective subtraction.** Inputs A = 0x3800, B = 0xBC00.
  - Required: out_a = 0x8000, out_b = 0xC000, out_sign = 1, out_eff_sub = 1.
  - Check: (out_a + out_b) mod 2^16 = 0x4000.
- **Denormal and sticky.** Inputs A = 0x3C00, B = 0x0001.
  - Required: d = 14, out_b = 0x0001 (sticky only).
- **Specials.** Input B = 0x7C00 → out_special = 1.
- **Backpressure and reset.**
  - Hold out_ready = 0 and stream 4 distinct pairs. Required: in_ready = 0 after 2 accepts.
  - Release out_ready. Required: outputs appear in order with no duplicates.
  - Then assert rst_n low while out_valid = 1. Required: out_valid = 0 immediately, no stale output after release.

Source files
------------

// File: rtl/fpa_pkg.sv
// ----------------------------------------------------------------------------
// fpa_pkg
// Shared constants, payload types and the binary16 unpack helper used by the
// half-precision operand aligner (fpa_align and fpa_align_shift).
// ----------------------------------------------------------------------------
package fpa_pkg;

    localparam int EXP_W   = 5;
    localparam int FRAC_W  = 10;
    localparam int SIG_W   = 16;
    localparam int GUARD_W = 5;

    localparam logic [EXP_W-1:0] EXP_SPECIAL = 5'd31;

    // Stage-1 payload: everything stage 2 needs to shift, negate and report.
    typedef struct packed {
        logic [EXP_W-1:0] d;          // e_big - e_small
        logic [EXP_W-1:0] exp;        // effective exponent of the big operand
        logic [SIG_W-1:0] sig_big;
        logic [SIG_W-1:0] sig_small;
        logic             sign;       // sign of the big operand
        logic             eff_sub;    // operand signs differ
        logic             special;    // either operand is Inf/NaN
    } fpa_s1_t;

    // One operand after unpacking.
    typedef struct packed {
        logic             sign;
        logic             special;
        logic [EXP_W-1:0] e;          // effective exponent (denormals use 1)
        logic [SIG_W-1:0] sig;        // {hidden, frac, guard zeros}
    } fpa_op_t;

    // Split a binary16 word into sign, effective exponent and a significand
    // with the hidden bit restored and guard bits appended.
    function automatic fpa_op_t fpa_unpack(input logic [15:0] x);
        fpa_op_t          u;
        logic [EXP_W-1:0] ex;
        ex        = x[14:10];
        u.sign    = x[15];
        u.special = (ex == EXP_SPECIAL);
        u.e       = (ex == 5'd0) ? 5'd1 : ex;
        u.sig     = {(ex != 5'd0), x[FRAC_W-1:0], {GUARD_W{1'b0}}};
        return u;
    endfunction

endpackage

// File: rtl/fpa_align_shift.sv
// ----------------------------------------------------------------------------
// fpa_align_shift
// Combinational right shifter for the smaller significand. Bits shifted out
// are OR-reduced into a sticky bit which is folded into bit 0 of the result.
// Shift amounts of 16 or more flush the whole significand into sticky.
//
// Ports:
//   sig  in  16  significand to shift
//   amt  in   5  shift amount (exponent difference)
//   sh   out 16  shifted significand with sticky folded into bit 0
// ----------------------------------------------------------------------------
module fpa_align_shift
    import fpa_pkg::*;
(
    input  logic [SIG_W-1:0] sig,
    input  logic [EXP_W-1:0] amt,
    output logic [SIG_W-1:0] sh
);

    logic [SIG_W-1:0] shifted_s;
    logic [SIG_W-1:0] lost_mask_s;
    logic             sticky_s;

    // Barrel shift plus sticky collection over the bits that fall off.
    always_comb begin
        shifted_s   = 16'd0;
        lost_mask_s = 16'd0;
        sticky_s    = 1'b0;
        if (amt < 5'd16) begin
            shifted_s   = sig >> amt;
            lost_mask_s = (16'd1 << amt) - 16'd1;
            sticky_s    = |(sig & lost_mask_s);
        end else begin
            shifted_s   = 16'd0;
            lost_mask_s = 16'hFFFF;
            sticky_s    = |sig;
        end
        sh = {shifted_s[SIG_W-1:1], shifted_s[0] | sticky_s};
    end

endmodule

// File: rtl/fpa_align.sv
// ----------------------------------------------------------------------------
// fpa_align
// Two-stage pipelined operand aligner for the binary16 adder.
//   Stage 1: unpack, magnitude compare/swap (A wins ties), exponent
//            difference, effective-subtract and special detection.
//   Stage 2: align the smaller significand with sticky, two's-complement it
//            for effective subtraction, and register all outputs.
// Valid/ready on both sides; each stage advances when empty or when the
// stage after it advances. in_ready is combinational from out_ready.
//
// Ports:
//   clk          in   1  clock, rising edge
//   rst_n        in   1  asynchronous active-low reset
//   in_valid     in   1  operand pair valid
//   in_ready     out  1  pair accepted this cycle when in_valid is high
//   in_a, in_b   in  16  binary16 operands
//   out_valid    out  1  aligned result valid
//   out_ready    in   1  downstream accepts the result
//   out_a        out 16  larger significand
//   out_b        out 16  smaller significand, aligned (negated if subtracting)
//   out_exp      out  5  effective exponent of the larger operand
//   out_sign     out  1  sign of the larger operand
//   out_eff_sub  out  1  operand signs differ
//   out_special  out  1  either operand is Inf/NaN (data then don't-care)
// ----------------------------------------------------------------------------
module fpa_align
    import fpa_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SIG_W-1:0] out_a,
    output logic [SIG_W-1:0] out_b,
    output logic [EXP_W-1:0] out_exp,
    output logic             out_sign,
    output logic             out_eff_sub,
    output logic             out_special
);

    fpa_op_t          ua_s;
    fpa_op_t          ub_s;
    logic             a_big_s;
    fpa_s1_t          s1_next_s;
    fpa_s1_t          s1_r;
    logic             s1_valid_r;
    logic             s1_adv_s;
    logic             s2_adv_s;
    logic [SIG_W-1:0] sh_s;
    logic [SIG_W-1:0] out_b_next_s;

    // Pipeline advance conditions; the output register is stage 2.
    assign s2_adv_s = ~out_valid | out_ready;
    assign s1_adv_s = ~s1_valid_r | s2_adv_s;
    assign in_ready = s1_adv_s;

    // Unpack both operands and order them by magnitude. Comparing the raw
    // {exp, frac} field is a magnitude compare for binary16, including
    // denormals; A is treated as big on a tie.
    always_comb begin
        ua_s      = fpa_unpack(in_a);
        ub_s      = fpa_unpack(in_b);
        a_big_s   = (in_a[14:0] >= in_b[14:0]);
        s1_next_s = '0;
        if (a_big_s) begin
            s1_next_s.d         = ua_s.e - ub_s.e;
            s1_next_s.exp       = ua_s.e;
            s1_next_s.sig_big   = ua_s.sig;
            s1_next_s.sig_small = ub_s.sig;
            s1_next_s.sign      = ua_s.sign;
        end else begin
            s1_next_s.d         = ub_s.e - ua_s.e;
            s1_next_s.exp       = ub_s.e;
            s1_next_s.sig_big   = ub_s.sig;
            s1_next_s.sig_small = ua_s.sig;
            s1_next_s.sign      = ub_s.sign;
        end
        s1_next_s.eff_sub = ua_s.sign ^ ub_s.sign;
        s1_next_s.special = ua_s.special | ub_s.special;
    end

    // Stage-1 register: captures a new pair whenever the stage may advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_r       <= '0;
        end else begin
            if (s1_adv_s) begin
                s1_valid_r <= in_valid;
                if (in_valid) begin
                    s1_r <= s1_next_s;
                end
            end
        end
    end

    fpa_align_shift u_shift (
        .sig (s1_r.sig_small),
        .amt (s1_r.d),
        .sh  (sh_s)
    );

    // Conditional two's complement so the adder can simply add the pair.
    always_comb begin
        out_b_next_s = sh_s;
        if (s1_r.eff_sub) begin
            out_b_next_s = ~sh_s + 16'd1;
        end else begin
            out_b_next_s = sh_s;
        end
    end

    // Stage-2 / output register: holds stable while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_a       <= 16'd0;
            out_b       <= 16'd0;
            out_exp     <= 5'd0;
            out_sign    <= 1'b0;
            out_eff_sub <= 1'b0;
            out_special <= 1'b0;
        end else begin
            if (s2_adv_s) begin
                out_valid <= s1_valid_r;
                if (s1_valid_r) begin
                    out_a       <= s1_r.sig_big;
                    out_b       <= out_b_next_s;
                    out_exp     <= s1_r.exp;
                    out_sign    <= s1_r.sign;
                    out_eff_sub <= s1_r.eff_sub;
                    out_special <= s1_r.special;
                end
            end
        end
    end

endmodule

// File: tb/tb_fpa_align.sv
// ----------------------------------------------------------------------------
// tb_fpa_align
// Directed bench for fpa_align. An integer-arithmetic model predicts each
// result from the operand pair; a queue tracks accepted pairs and a single
// negedge compare process checks every output transfer, output stability
// under backpressure, and quiet outputs during/after reset.
// ----------------------------------------------------------------------------
module tb_fpa_align;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_a;
    logic [15:0] out_b;
    logic [4:0]  out_exp;
    logic        out_sign;
    logic        out_eff_sub;
    logic        out_special;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] oa;
        logic [15:0] ob;
        logic [4:0]  oexp;
        logic        sign;
        logic        eff;
        logic        spec;
    } item_t;

    item_t q[$];
    item_t vecs[8];

    logic        hold_chk = 1'b0;
    logic [31:0] snap_ab;
    logic [31:0] snap_ctl;

    fpa_align dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_exp     (out_exp),
        .out_sign    (out_sign),
        .out_eff_sub (out_eff_sub),
        .out_special (out_special)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, want);
        end
    endtask

    // Reference: plain arithmetic on exponents and significands.
    function automatic item_t model(input logic [15:0] a, input logic [15:0] b);
        item_t r;
        int xa, xb, ea, eb, sga, sgb, ebig, esm, sbig, ssm, d, sh, lost;
        xa  = int'(a[14:10]);
        xb  = int'(b[14:10]);
        ea  = (xa == 0) ? 1 : xa;
        eb  = (xb == 0) ? 1 : xb;
        sga = (((xa != 0) ? 1024 : 0) + int'(a[9:0])) * 32;
        sgb = (((xb != 0) ? 1024 : 0) + int'(b[9:0])) * 32;
        r.a    = a;
        r.b    = b;
        r.eff  = a[15] ^ b[15];
        r.spec = (xa == 31) || (xb == 31);
        if (int'(a[14:0]) >= int'(b[14:0])) begin
            ebig = ea; esm = eb; sbig = sga; ssm = sgb; r.sign = a[15];
        end else begin
            ebig = eb; esm = ea; sbig = sgb; ssm = sga; r.sign = b[15];
        end
        d = ebig - esm;
        if (d >= 16) begin
            sh = 0; lost = ssm;
        end else begin
            sh = ssm / (1 << d); lost = ssm % (1 << d);
        end
        if (lost != 0) sh = sh | 1;
        if (r.eff) sh = (65536 - sh) % 65536;
        r.oa   = 16'(sbig);
        r.ob   = 16'(sh);
        r.oexp = 5'(ebig);
        return r;
    endfunction

    // Scoreboard: record accepts, check every output transfer and stalls.
    always @(negedge clk) begin
        item_t e;
        if (!rst_n) begin
            chk("reset_out_valid", 32'(out_valid), 32'd0);
            hold_chk = 1'b0;
        end else begin
            if (hold_chk) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", {out_a, out_b}, snap_ab);
                chk("hold_ctl", 32'({out_exp, out_sign, out_eff_sub, out_special}), snap_ctl);
            end
            hold_chk = 1'b0;
            if (out_valid && !out_ready) begin
                hold_chk = 1'b1;
                snap_ab  = {out_a, out_b};
                snap_ctl = 32'({out_exp, out_sign, out_eff_sub, out_special});
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_out got=valid a=%h b=%h want=no_result", out_a, out_b);
                end else begin
                    e = q.pop_front();
                    chk($sformatf("special_%h_%h", e.a, e.b), 32'(out_special), 32'(e.spec));
                    if (!e.spec) begin
                        chk($sformatf("out_a_%h_%h", e.a, e.b), 32'(out_a), 32'(e.oa));
                        chk($sformatf("out_b_%h_%h", e.a, e.b), 32'(out_b), 32'(e.ob));
                        chk($sformatf("out_exp_%h_%h", e.a, e.b), 32'(out_exp), 32'(e.oexp));
                        chk($sformatf("out_sign_%h_%h", e.a, e.b), 32'(out_sign), 32'(e.sign));
                        chk($sformatf("eff_sub_%h_%h", e.a, e.b), 32'(out_eff_sub), 32'(e.eff));
                        if (e.a == 16'h3800 && e.b == 16'hBC00) begin
                            chk("sub_sum", 32'(16'(out_a + out_b)), 32'h4000);
                        end
                    end
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(in_a, in_b));
            end
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b);
        int n;
        n = 0;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout got=in_ready_low want=accept a=%h b=%h", a, b);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0 || out_valid) begin
            total++;
            bad++;
            $display("FAIL drain_timeout got=pending%0d want=0", q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // a, b, out_a, out_b, out_exp, sign, eff_sub, special (hand-computed)
        vecs[0] = '{16'h3C00, 16'h3C00, 16'h8000, 16'h8000, 5'd15, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h3C00, 16'h3800, 16'h8000, 16'h4000, 5'd15, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{16'h3800, 16'hBC00, 16'h8000, 16'hC000, 5'd15, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{16'h3C00, 16'h0001, 16'h8000, 16'h0001, 5'd15, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{16'h3C00, 16'h7C00, 16'h0000, 16'h0000, 5'd0,  1'b0, 1'b0, 1'b1};
        vecs[5] = '{16'h0001, 16'h8001, 16'h0020, 16'hFFE0, 5'd1,  1'b0, 1'b1, 1'b0};
        vecs[6] = '{16'h4A00, 16'hB155, 16'hC000, 16'hFD55, 5'd18, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{16'h7BFF, 16'h0200, 16'hFFE0, 16'h0001, 5'd30, 1'b0, 1'b0, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = 16'h0000;
        in_b      = 16'h0000;
        out_ready = 1'b1;

        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_ab", {out_a, out_b}, 32'd0);
        chk("rst_out_ctl", 32'({out_exp, out_sign, out_eff_sub, out_special}), 32'd0);
        #19;
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset", 32'(in_ready), 32'd1);

        // Pin the model against hand-computed values.
        for (int i = 0; i < 8; i++) begin
            item_t m;
            m = model(vecs[i].a, vecs[i].b);
            chk($sformatf("model_spec_%0d", i), 32'(m.spec), 32'(vecs[i].spec));
            if (!vecs[i].spec) begin
                chk($sformatf("model_oa_%0d", i), 32'(m.oa), 32'(vecs[i].oa));
                chk($sformatf("model_ob_%0d", i), 32'(m.ob), 32'(vecs[i].ob));
                chk($sformatf("model_exp_%0d", i), 32'(m.oexp), 32'(vecs[i].oexp));
                chk($sformatf("model_sign_%0d", i), 32'(m.sign), 32'(vecs[i].sign));
                chk($sformatf("model_eff_%0d", i), 32'(m.eff), 32'(vecs[i].eff));
            end
        end

        // Directed vectors back to back at full throughput.
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].a, vecs[i].b);
        end
        in_valid = 1'b0;
        drain();

        // Latency: driven just after edge k, result valid after edge k+2.
        @(posedge clk);
        #1;
        in_a     = 16'h4000;
        in_b     = 16'h3C00;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("latency_k1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("latency_k2_valid", 32'(out_valid), 32'd1);
        drain();

        // Backpressure: two accepts fill the pipe, then in_ready drops.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(16'h3C00, 16'h3800);
        send(16'h4000, 16'h3C00);
        in_a     = 16'h4400;
        in_b     = 16'hC000;
        in_valid = 1'b1;
        @(negedge clk);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_accepts", 32'(q.size()), 32'd2);
        repeat (3) @(negedge clk);
        chk("bp_in_ready_held", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(16'h4400, 16'hC000);
        send(16'h3555, 16'h3155);
        in_valid = 1'b0;
        drain();

        // Reset while a result is being held.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(16'h4800, 16'h3C00);
        send(16'h3C00, 16'hB800);
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_reset_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("mid_reset_valid", 32'(out_valid), 32'd0);
        chk("mid_reset_ab", {out_a, out_b}, 32'd0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_reset_valid", 32'(out_valid), 32'd0);
        chk("post_reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        send(16'h3C00, 16'h0001);
        in_valid = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
